// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester scratch-memory arbiter.
//
// Contents:
//   arb_state_e  - arbiter ownership state (idle, owned by host, owned by device)
//   REQ_HOST     - requester id of the host command engine (port 0)
//   REQ_DEV      - requester id of the device core (port 1)
//   own_state()  - maps a requester id onto the state in which it owns the memory
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_e;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_DEV  = 1'b1;

    function automatic arb_state_e own_state(input logic id);
        return (id == REQ_DEV) ? ARB_OWN1 : ARB_OWN0;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester burst arbiter for the single-port scratch memory.
//
// Requester 0 (host command engine) and requester 1 (device core) each present one beat per
// cycle. Ownership is granted per burst; a burst ends on an accepted beat flagged last, on the
// MAX_BURST-th accepted beat (forced handover), or when the owner drops its request. At every
// burst end the round-robin pointer moves to the other requester, which takes over on the next
// cycle if it is requesting.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_req_k / i_we_k / i_addr_k    beat request, write flag and address of requester k
//   i_wdata_k / i_last_k           write data and end-of-burst flag of requester k
//   o_gnt_k                        beat of requester k accepted this cycle (combinational)
//   o_rvalid_k                     o_rdata carries read data for requester k
//   o_rdata                        shared read data, straight from i_mem_rdata
//   o_mem_en / o_mem_we            memory enable / write enable
//   o_mem_addr / o_mem_wdata       memory address / write data (don't-care while o_mem_en=0)
//   i_mem_rdata                    memory read data, valid one cycle after a read enable
//   o_busy                         arbiter is not idle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_req_0,
    input  logic                 i_we_0,
    input  logic [ADDR_BITS-1:0] i_addr_0,
    input  logic [DATA_BITS-1:0] i_wdata_0,
    input  logic                 i_last_0,

    input  logic                 i_req_1,
    input  logic                 i_we_1,
    input  logic [ADDR_BITS-1:0] i_addr_1,
    input  logic [DATA_BITS-1:0] i_wdata_1,
    input  logic                 i_last_1,

    output logic                 o_gnt_0,
    output logic                 o_gnt_1,
    output logic                 o_rvalid_0,
    output logic                 o_rvalid_1,
    output logic [DATA_BITS-1:0] o_rdata,

    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [DATA_BITS-1:0] o_mem_wdata,
    input  logic [DATA_BITS-1:0] i_mem_rdata,

    output logic                 o_busy
);

    // One extra bit so MAX_BURST itself is representable for any MAX_BURST >= 1.
    localparam int unsigned         CntW    = $clog2(MAX_BURST) + 1;
    localparam logic [CntW-1:0]     CntLast = CntW'(MAX_BURST - 1);

    arb_state_e          state_q, state_d;
    logic                ptr_q, ptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                rvalid0_q, rvalid1_q;

    logic                own_any;
    logic                owner;
    logic                own_req;
    logic                own_we;
    logic                own_last;
    logic [ADDR_BITS-1:0] own_addr;
    logic [DATA_BITS-1:0] own_wdata;
    logic                other_req;
    logic                gnt0;
    logic                gnt1;
    logic                accept;
    logic                burst_end;
    logic                idle_pick;

    // Owner-side request mux.
    always_comb begin
        own_any = (state_q != ARB_IDLE);
        owner   = (state_q == ARB_OWN1) ? REQ_DEV : REQ_HOST;
        if (owner == REQ_DEV) begin
            own_req   = i_req_1;
            own_we    = i_we_1;
            own_last  = i_last_1;
            own_addr  = i_addr_1;
            own_wdata = i_wdata_1;
            other_req = i_req_0;
        end else begin
            own_req   = i_req_0;
            own_we    = i_we_0;
            own_last  = i_last_0;
            own_addr  = i_addr_0;
            own_wdata = i_wdata_0;
            other_req = i_req_1;
        end
    end

    // Grants are gated by reset so the memory port goes quiet in the reset cycle itself.
    always_comb begin
        gnt0   = i_rst_n & (state_q == ARB_OWN0) & i_req_0;
        gnt1   = i_rst_n & (state_q == ARB_OWN1) & i_req_1;
        accept = gnt0 | gnt1;
        // Dropping the request ends the burst with nothing accepted; otherwise the beat is
        // accepted and may close the burst by its last flag or by hitting the beat limit.
        burst_end = own_any & (~own_req | own_last | (cnt_q == CntLast));
        // From idle: the favoured requester wins if it asks, otherwise the other one.
        if (ptr_q == REQ_DEV) begin
            idle_pick = i_req_1 ? REQ_DEV : REQ_HOST;
        end else begin
            idle_pick = i_req_0 ? REQ_HOST : REQ_DEV;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (i_req_0 | i_req_1) begin
                    state_d = own_state(idle_pick);
                    cnt_d   = '0;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (burst_end) begin
                    ptr_d   = ~owner;
                    state_d = other_req ? own_state(~owner) : ARB_IDLE;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= REQ_HOST;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            // Memory returns read data one cycle after the accepting cycle.
            rvalid0_q <= gnt0 & ~i_we_0;
            rvalid1_q <= gnt1 & ~i_we_1;
        end
    end

    assign o_gnt_0     = gnt0;
    assign o_gnt_1     = gnt1;
    assign o_rvalid_0  = rvalid0_q;
    assign o_rvalid_1  = rvalid1_q;
    assign o_rdata     = i_mem_rdata;
    assign o_mem_en    = accept;
    assign o_mem_we    = accept & own_we;
    assign o_mem_addr  = own_addr;
    assign o_mem_wdata = own_wdata;
    assign o_busy      = own_any;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single-port 16K x 8 scratch memory between the host command engine (requester 0) and the device core (requester 1). It grants whole bursts, alternates ownership round-robin at burst boundaries and forces a handover after MAX_BURST beats so neither side starves. It drives the memory port directly and returns read data with per-requester valid strobes.

## Interface
- ADDR_BITS, 14, memory address width
- DATA_BITS, 8, memory data width
- MAX_BURST, 16, maximum accepted beats per grant (≥1)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_req_k  in  1  requester k (k=0,1) wants a beat this cycle
- i_we_k  in  1  beat is a write (1) or read (0)
- i_addr_k  in  ADDR_BITS  beat address
- i_wdata_k  in  DATA_BITS  write data
- i_last_k  in  1  final beat of requester's burst
- o_gnt_k  out  1  beat accepted this cycle (combinational)
- o_rvalid_k  out  1  o_rdata holds read data for requester k
- o_rdata  out  DATA_BITS  read data, shared, = i_mem_rdata
- o_mem_en, o_mem_we  out  1  memory enable / write enable
- o_mem_addr  out  ADDR_BITS;  o_mem_wdata  out  DATA_BITS
- i_mem_rdata  in  DATA_BITS  memory read data, 1-cycle latency after o_mem_en
- o_busy  out  1  state != IDLE

## Operation
- States IDLE, OWN0, OWN1; round-robin pointer p (requester favoured next); beat counter cnt, width $clog2(MAX_BURST)+1.
- IDLE: no grants. If any i_req_k: next state OWN of requester chosen by p (requester p if requesting, else the other); cnt<=0.
- OWNk: o_gnt_k = i_req_k; o_gnt of other = 0. Accepted beat = o_gnt_k: o_mem_en=1, o_mem_we/addr/wdata = requester k's inputs; cnt<=cnt+1.
- Burst end when: accepted beat with i_last_k=1; or accepted beat with cnt==MAX_BURST-1 (forced); or i_req_k=0 in OWNk (abandon, nothing accepted).
- On burst end: p <= other; next state OWN(other) if other's i_req is high that cycle, else IDLE; cnt<=0.
- Memory port idle (o_mem_en=0) whenever no beat accepted; o_mem_addr/wdata don't-care then.
- o_rvalid_k registered: <= accepted read beat of k. o_rdata passes i_mem_rdata unregistered.
- Reset values: state IDLE, p=0, cnt=0, o_rvalid_k=0, o_gnt_k=0, o_mem_en=0, o_busy=0.

## Timing
- Arbitration bubble: first request from IDLE is granted one cycle after it is raised.
- Back-to-back handover: no bubble; other requester granted cycle after burst end.
- Throughput: one beat per cycle while owner holds req.
- Read latency: o_rvalid_k one cycle after the accepting cycle.
- Simultaneous requests in IDLE: requester p wins; after reset requester 0 wins.
- MAX_BURST=1: ownership alternates every beat when both request.
- Reset mid-burst: grants and o_mem_en drop in the reset cycle; o_rvalid for any beat in flight is cleared and not reissued.
- Address wraps naturally in ADDR_BITS; arbiter performs no address arithmetic.

## Structure
- mem_arbiter_pkg: state enum (ARB_IDLE, ARB_OWN0, ARB_OWN1), requester-id constants REQ_HOST=0, REQ_DEV=1.
- No sub-module; single module, one state register block plus combinational grant/mux logic.

## Test plan
- Reset, then req0 4-beat write burst addr 0x0010..0x0013 data 0xA0..0xA3, last on beat 4 -> gnt0 from cycle 2, four o_mem_we pulses, return to IDLE.
- Both req from IDLE, each 3-beat burst -> requester 0 first, requester 1 granted cycle after beat 3 with no bubble; p ends at 0.
- req1 holds req, no last, 40 beats, req0 waiting, MAX_BURST=16 -> forced handover after beat 16; req0 served; req1 resumes.
- req0 read addr 0x3FFF after write 0x5C -> o_rvalid_0 one cycle after grant, o_rdata=0x5C, o_rvalid_1 stays 0.
- Owner drops req mid-burst after 2 beats -> burst abandoned, next owner/IDLE per rule, cnt reset.
- Assert i_rst_n=0 during accepted read beat -> o_gnt, o_mem_en, o_rvalid all 0 next cycle, state IDLE, p=0.
